spi_cmd_deframer: RTL and testbench
===================================

Name: spi_cmd_deframer

Overview:
- Front end of the on-chip SPI responder.
- Deserialises the controller's MOSI (pico) stream into a command byte and then one or more data bytes.
- Presents address, write data and single-cycle write/read request strobes to the register bank.
- Supports burst transfers with address auto-increment; frames are delimited by cs, which is folded into full_rstn.

Parameters:
- NUM_WR_REGS, 11, highest valid register address; valid range is 1..NUM_WR_REGS.
- AUTO_INC, 1, 1 = increment address after each data byte; 0 = hold address for the whole frame.
- CNT_W, 8, width of the data-byte counter, which saturates.

Ports:
- spi_clk  input  1  SPI clock; pico sampled on posedge.
- full_rstn  input  1  asynchronous active-low reset (rstn & cs); low between frames.
- pico  input  1  serial data from controller, MSB first.
- is_write  output  1  command bit 7 of the current frame.
- addr  output  7  current register address.
- wdata  output  8  last completed data byte.
- wr_valid  output  1  one-cycle write strobe.
- rd_req  output  1  one-cycle read-load request for addr.
- addr_err  output  1  sticky flag: an access targeted an address outside 1..NUM_WR_REGS.
- byte_cnt  output  CNT_W  count of completed data bytes in the frame, saturating.
- cmd_done  output  1  high once the command byte has been received.

Behaviour:
- Reset (full_rstn low, async): state=CMD, bit_cnt=0, shift reg=0. All outputs are 0: is_write, addr, wdata, wr_valid, rd_req, addr_err, byte_cnt, cmd_done.
- Reset is the only frame delimiter. A partial byte in progress when cs drops is discarded and never written.
- bit_cnt is 3 bits and counts posedges within a byte (0..7). It wraps 7->0 on byte completion.
- A byte completes on the 8th posedge. The completed value is {shreg[6:0], pico}, sampled on that edge.
- State CMD, on byte completion:
  - is_write <= byte[7]; addr <= byte[6:0]; cmd_done <= 1; state -> DATA.
  - If !byte[7]: rd_req <= 1 for one cycle. Set addr_err if the address is invalid.
- State DATA, on byte completion:
  - wdata <= byte; byte_cnt <= byte_cnt+1, saturating at 2^CNT_W-1.
  - If is_write and addr is valid: wr_valid <= 1 for one cycle.
  - If is_write and addr is invalid: wr_valid stays 0 and addr_err <= 1.
- Next posedge after a DATA byte completes (the first bit of the following byte):
  - wr_valid <= 0.
  - If AUTO_INC: addr <= addr+1, wrapping 127->0; 0 is invalid.
  - If AUTO_INC and !is_write: rd_req <= 1 for that cycle. addr_err <= 1 if the new addr is invalid.
- When AUTO_INC=0, addr is constant for the frame, and rd_req fires only after the command byte.
- Latency:
  - wr_valid/wdata are valid in the cycle following the 8th data edge.
  - rd_req coincides with the cycle in which addr is valid.
- wr_valid and rd_req are never high together. wr_valid is never high in CMD.
- addr_err, once set, holds until reset.
- No state beyond DATA. Extra bytes continue the burst indefinitely.

Decomposition:
- Package psec6_spi_pkg:
  - typedef enum logic {ST_CMD, ST_DATA} spi_frame_state_t.
  - localparams SPI_ADDR_W=7, SPI_BYTE_W=8, SPI_RW_BIT=7.
  - Function addr_is_valid(addr, NUM_WR_REGS).
- Sub-module spi_shift_in: 8-bit MSB-first shift register plus 3-bit bit counter with a byte_done pulse output, reset by full_rstn.
- Top level holds the FSM, address/strobe logic, counter and error flag.

Test Plan:
- Write 0x02 then 0xA5 (16 clocks) -> after clock 16: is_write=1, addr=2, wdata=0xA5, wr_valid high exactly 1 cycle, byte_cnt=1, addr_err=0.
- Burst write cmd 0x0A, data 0x11,0x22,0x33 with AUTO_INC=1 -> three wr_valid pulses at addr 10, 11, 12; third sets addr_err=1 with no write at 12; byte_cnt=3.
- Read cmd 0x05 then 16 more clocks -> rd_req pulse after clock 8 with addr=5; after clock 17, rd_req with addr=6; wr_valid never asserts.
- Write cmd 0x03, then cs deasserted after 5 data bits -> no wr_valid; all outputs return to 0 asynchronously.
- Write to addr 0x7F then 2 data bytes -> no wr_valid; addr wraps to 0; addr_err=1 sticky.
- AUTO_INC=0, write cmd 0x04, data 0x01,0x02 -> two wr_valid pulses both at addr 4, final wdata=0x02.

Source files
------------

// File: rtl/spi_cmd_deframer_pkg.sv
// Shared types, widths and address check for the SPI command deframer.
package psec6_spi_pkg;

  typedef enum logic {ST_CMD = 1'b0, ST_DATA = 1'b1} spi_frame_state_t;

  localparam int SPI_ADDR_W = 7;
  localparam int SPI_BYTE_W = 8;
  localparam int SPI_RW_BIT = 7;

  // Register address 0 is reserved, so the valid window starts at 1.
  function automatic logic addr_is_valid(input logic [SPI_ADDR_W-1:0] addr,
                                         input int num_wr_regs);
    return (addr != 7'd0) && (int'(addr) <= num_wr_regs);
  endfunction

endpackage

// File: rtl/spi_cmd_deframer_shift_in.sv
// MSB-first deserialiser: 3-bit position counter plus shift register.
// The completed byte is combinational, so the top acts on the 8th edge itself.
module spi_shift_in
  import psec6_spi_pkg::*;
(
  input  logic                  spi_clk,
  input  logic                  full_rstn,
  input  logic                  pico,
  output logic                  byte_done,
  output logic [SPI_BYTE_W-1:0] byte_val
);

  // Only seven stored bits are ever needed; the eighth comes live from pico.
  logic [SPI_BYTE_W-2:0] shreg_q;
  logic [2:0]            bit_cnt_q;

  // Shift in one bit per edge and track the position within the byte.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      shreg_q   <= 7'd0;
      bit_cnt_q <= 3'd0;
    end else begin
      shreg_q   <= {shreg_q[SPI_BYTE_W-3:0], pico};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  assign byte_done = (bit_cnt_q == 3'd7);
  assign byte_val  = {shreg_q, pico};

endmodule

// File: rtl/spi_cmd_deframer.sv
// SPI responder front end: command byte decode, burst data bytes, address
// auto-increment and single-cycle write/read strobes for the register bank.
module spi_cmd_deframer
  import psec6_spi_pkg::*;
#(
  parameter int NUM_WR_REGS = 11,
  parameter int AUTO_INC    = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  spi_clk,
  input  logic                  full_rstn,
  input  logic                  pico,
  output logic                  is_write,
  output logic [SPI_ADDR_W-1:0] addr,
  output logic [SPI_BYTE_W-1:0] wdata,
  output logic                  wr_valid,
  output logic                  rd_req,
  output logic                  addr_err,
  output logic [CNT_W-1:0]      byte_cnt,
  output logic                  cmd_done
);

  spi_frame_state_t      state_q;
  logic                  is_write_q;
  logic [SPI_ADDR_W-1:0] addr_q;
  logic [SPI_BYTE_W-1:0] wdata_q;
  logic                  wr_valid_q;
  logic                  rd_req_q;
  logic                  addr_err_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic                  cmd_done_q;
  logic                  data_done_q;

  logic                  byte_done_s;
  logic [SPI_BYTE_W-1:0] byte_s;
  logic [SPI_ADDR_W-1:0] addr_next_s;

  spi_shift_in u_shift_in (
    .spi_clk   (spi_clk),
    .full_rstn (full_rstn),
    .pico      (pico),
    .byte_done (byte_done_s),
    .byte_val  (byte_s)
  );

  assign addr_next_s = addr_q + 7'd1;

  // Frame FSM; the strobes default low so each lasts exactly one cycle.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      state_q     <= ST_CMD;
      is_write_q  <= 1'b0;
      addr_q      <= 7'd0;
      wdata_q     <= 8'd0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      byte_cnt_q  <= {CNT_W{1'b0}};
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      data_done_q <= 1'b0;
      case (state_q)
        ST_CMD: begin
          if (byte_done_s) begin
            is_write_q <= byte_s[SPI_RW_BIT];
            addr_q     <= byte_s[SPI_ADDR_W-1:0];
            cmd_done_q <= 1'b1;
            state_q    <= ST_DATA;
            if (!byte_s[SPI_RW_BIT]) begin
              rd_req_q <= 1'b1;
              if (!addr_is_valid(byte_s[SPI_ADDR_W-1:0], NUM_WR_REGS)) begin
                addr_err_q <= 1'b1;
              end
            end
          end
        end
        ST_DATA: begin
          if (byte_done_s) begin
            wdata_q     <= byte_s;
            data_done_q <= 1'b1;
            if (byte_cnt_q != {CNT_W{1'b1}}) begin
              byte_cnt_q <= byte_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (is_write_q) begin
              if (addr_is_valid(addr_q, NUM_WR_REGS)) begin
                wr_valid_q <= 1'b1;
              end else begin
                addr_err_q <= 1'b1;
              end
            end
          end else if (data_done_q && (AUTO_INC != 0)) begin
            // Advance on the first bit of the next byte so reads can preload.
            addr_q <= addr_next_s;
            if (!is_write_q) begin
              rd_req_q <= 1'b1;
              if (!addr_is_valid(addr_next_s, NUM_WR_REGS)) begin
                addr_err_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= ST_CMD;
      endcase
    end
  end

  assign is_write = is_write_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign wr_valid = wr_valid_q;
  assign rd_req   = rd_req_q;
  assign addr_err = addr_err_q;
  assign byte_cnt = byte_cnt_q;
  assign cmd_done = cmd_done_q;

endmodule

// File: tb/tb_spi_cmd_deframer.sv
// Directed bench for spi_cmd_deframer: one instance with auto-increment,
// one without, sharing clock, reset and serial input.
module tb_spi_cmd_deframer;

  logic       spi_clk = 1'b0;
  logic       full_rstn = 1'b0;
  logic       pico = 1'b0;

  logic       is_write, wr_valid, rd_req, addr_err, cmd_done;
  logic [6:0] addr;
  logic [7:0] wdata, byte_cnt;

  logic       n_is_write, n_wr_valid, n_rd_req, n_addr_err, n_cmd_done;
  logic [6:0] n_addr;
  logic [7:0] n_wdata, n_byte_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 spi_clk = ~spi_clk;

  spi_cmd_deframer #(.NUM_WR_REGS(11), .AUTO_INC(1), .CNT_W(8)) u_dut (
    .spi_clk(spi_clk), .full_rstn(full_rstn), .pico(pico),
    .is_write(is_write), .addr(addr), .wdata(wdata), .wr_valid(wr_valid),
    .rd_req(rd_req), .addr_err(addr_err), .byte_cnt(byte_cnt), .cmd_done(cmd_done)
  );

  spi_cmd_deframer #(.NUM_WR_REGS(11), .AUTO_INC(0), .CNT_W(8)) u_dut_ni (
    .spi_clk(spi_clk), .full_rstn(full_rstn), .pico(pico),
    .is_write(n_is_write), .addr(n_addr), .wdata(n_wdata), .wr_valid(n_wr_valid),
    .rd_req(n_rd_req), .addr_err(n_addr_err), .byte_cnt(n_byte_cnt), .cmd_done(n_cmd_done)
  );

  // Drive one bit ahead of the edge, then sample 1 time unit after it.
  task automatic send_bit(input logic b);
    pico = b;
    @(posedge spi_clk);
    #1;
    n_vec++;
    if ((wr_valid && rd_req) !== 1'b0) begin
      n_err++;
      $display("FAIL strobe_excl: wr_valid=%b rd_req=%b both high", wr_valid, rd_req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_frame();
    full_rstn = 1'b0;
    #2;
    @(negedge spi_clk);
    full_rstn = 1'b1;
  endtask

  task automatic end_frame_check(input string name);
    full_rstn = 1'b0;
    #1;
    n_vec++;
    if ({is_write, addr, wdata, wr_valid, rd_req, addr_err, byte_cnt, cmd_done} !== 28'd0) begin
      n_err++;
      $display("FAIL %s_reset: outputs=%h required 0", name,
               {is_write, addr, wdata, wr_valid, rd_req, addr_err, byte_cnt, cmd_done});
    end
  endtask

  task automatic test_reset();
    full_rstn = 1'b0;
    #3;
    n_vec++;
    if ({is_write, addr, wdata, wr_valid, rd_req, addr_err, byte_cnt, cmd_done} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_a: outputs=%h required 0",
               {is_write, addr, wdata, wr_valid, rd_req, addr_err, byte_cnt, cmd_done});
    end
    n_vec++;
    if ({n_is_write, n_addr, n_wdata, n_wr_valid, n_rd_req, n_addr_err, n_byte_cnt, n_cmd_done} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_b: outputs=%h required 0",
               {n_is_write, n_addr, n_wdata, n_wr_valid, n_rd_req, n_addr_err, n_byte_cnt, n_cmd_done});
    end
  endtask

  task automatic test_single_write();
    start_frame();
    send_byte(8'h82);
    n_vec++;
    if ({cmd_done, is_write, addr, wr_valid, rd_req} !== {1'b1, 1'b1, 7'd2, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sw_cmd: done/wr/addr/wv/rd=%b/%b/%0d/%b/%b required 1/1/2/0/0",
               cmd_done, is_write, addr, wr_valid, rd_req);
    end
    send_byte(8'hA5);
    n_vec++;
    if ({wdata, wr_valid, addr, byte_cnt, addr_err} !== {8'hA5, 1'b1, 7'd2, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL sw_data: wdata=%h wv=%b addr=%0d cnt=%0d err=%b required a5 1 2 1 0",
               wdata, wr_valid, addr, byte_cnt, addr_err);
    end
    send_bit(1'b0);
    n_vec++;
    if ({wr_valid, addr, rd_req} !== {1'b0, 7'd3, 1'b0}) begin
      n_err++;
      $display("FAIL sw_after: wv=%b addr=%0d rd=%b required 0 3 0", wr_valid, addr, rd_req);
    end
    end_frame_check("sw");
  endtask

  task automatic test_burst();
    logic [7:0] data_v [3] = '{8'h11, 8'h22, 8'h33};
    logic       wv_v   [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0] addr_v [3] = '{7'd10, 7'd11, 7'd12};
    logic       err_v  [3] = '{1'b0, 1'b0, 1'b1};
    start_frame();
    send_byte(8'h8A);
    for (int k = 0; k < 3; k++) begin
      send_byte(data_v[k]);
      n_vec++;
      if ({wr_valid, addr, addr_err, wdata, byte_cnt} !==
          {wv_v[k], addr_v[k], err_v[k], data_v[k], 8'(k + 1)}) begin
        n_err++;
        $display("FAIL burst_%0d: wv=%b addr=%0d err=%b wdata=%h cnt=%0d required %b %0d %b %h %0d",
                 k, wr_valid, addr, addr_err, wdata, byte_cnt,
                 wv_v[k], addr_v[k], err_v[k], data_v[k], k + 1);
      end
    end
  endtask

  task automatic test_read();
    int wv_seen = 0;
    start_frame();
    send_byte(8'h05);
    n_vec++;
    if ({rd_req, addr, is_write, addr_err} !== {1'b1, 7'd5, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rd_cmd: rd=%b addr=%0d wr=%b err=%b required 1 5 0 0",
               rd_req, addr, is_write, addr_err);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (wr_valid || rd_req) wv_seen++;
    end
    n_vec++;
    if ({wv_seen, byte_cnt, addr} !== {32'd0, 8'd1, 7'd5}) begin
      n_err++;
      $display("FAIL rd_byte: strobes=%0d cnt=%0d addr=%0d required 0 1 5", wv_seen, byte_cnt, addr);
    end
    send_bit(1'b0);
    n_vec++;
    if ({rd_req, addr, wr_valid, addr_err} !== {1'b1, 7'd6, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rd_inc: rd=%b addr=%0d wv=%b err=%b required 1 6 0 0",
               rd_req, addr, wr_valid, addr_err);
    end
    send_bit(1'b0);
    n_vec++;
    if (rd_req !== 1'b0) begin
      n_err++;
      $display("FAIL rd_pulse: rd=%b required 0", rd_req);
    end
  endtask

  task automatic test_partial();
    int wv_seen = 0;
    start_frame();
    send_byte(8'h83);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      if (wr_valid) wv_seen++;
    end
    n_vec++;
    if ({wv_seen, byte_cnt} !== {32'd0, 8'd0}) begin
      n_err++;
      $display("FAIL partial: wr pulses=%0d cnt=%0d required 0 0", wv_seen, byte_cnt);
    end
    #2;
    end_frame_check("partial");
  endtask

  task automatic test_wrap();
    start_frame();
    send_byte(8'hFF);
    n_vec++;
    if ({addr, addr_err} !== {7'd127, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_cmd: addr=%0d err=%b required 127 0", addr, addr_err);
    end
    send_byte(8'h12);
    n_vec++;
    if ({wr_valid, addr_err, addr} !== {1'b0, 1'b1, 7'd127}) begin
      n_err++;
      $display("FAIL wrap_d1: wv=%b err=%b addr=%0d required 0 1 127", wr_valid, addr_err, addr);
    end
    send_bit(1'b0);
    n_vec++;
    if ({addr, addr_err} !== {7'd0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_inc: addr=%0d err=%b required 0 1", addr, addr_err);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    n_vec++;
    if ({wr_valid, addr_err, byte_cnt} !== {1'b0, 1'b1, 8'd2}) begin
      n_err++;
      $display("FAIL wrap_d2: wv=%b err=%b cnt=%0d required 0 1 2", wr_valid, addr_err, byte_cnt);
    end
  endtask

  task automatic test_no_inc();
    start_frame();
    send_byte(8'h84);
    send_byte(8'h01);
    n_vec++;
    if ({n_wr_valid, n_addr, n_wdata} !== {1'b1, 7'd4, 8'h01}) begin
      n_err++;
      $display("FAIL ni_d1: wv=%b addr=%0d wdata=%h required 1 4 01", n_wr_valid, n_addr, n_wdata);
    end
    send_bit(1'b0);
    n_vec++;
    if ({n_wr_valid, n_addr, n_rd_req} !== {1'b0, 7'd4, 1'b0}) begin
      n_err++;
      $display("FAIL ni_hold: wv=%b addr=%0d rd=%b required 0 4 0", n_wr_valid, n_addr, n_rd_req);
    end
    for (int i = 6; i >= 0; i--) send_bit(i == 1);
    n_vec++;
    if ({n_wr_valid, n_addr, n_wdata, n_byte_cnt, n_addr_err} !== {1'b1, 7'd4, 8'h02, 8'd2, 1'b0}) begin
      n_err++;
      $display("FAIL ni_d2: wv=%b addr=%0d wdata=%h cnt=%0d err=%b required 1 4 02 2 0",
               n_wr_valid, n_addr, n_wdata, n_byte_cnt, n_addr_err);
    end
  endtask

  task automatic test_saturate();
    start_frame();
    send_byte(8'h01);
    for (int k = 0; k < 255; k++) send_byte(8'h5A);
    n_vec++;
    if (byte_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL sat_255: cnt=%0d required 255", byte_cnt);
    end
    send_byte(8'h5A);
    n_vec++;
    if ({byte_cnt, addr_err} !== {8'd255, 1'b1}) begin
      n_err++;
      $display("FAIL sat_hold: cnt=%0d err=%b required 255 1", byte_cnt, addr_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_read();
    test_partial();
    test_wrap();
    test_no_inc();
    test_saturate();
    full_rstn = 1'b0;
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
